motor_pwm_gen: RTL and testbench

MOTOR_PWM_GEN -- requirements
Module: motor_pwm_gen

---
 rtl/motor_pwm_gen.sv | 132 +++++++++++++
 tb/tb_motor_pwm_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_gen.sv
// Four-channel ESC pulse generator: fixed-point motor rates -> 1000..2000 us pulses once per frame.
// Optional build macro MOTOR_SLEW_LIMIT_EN limits each width change to SLEW_US per frame.

module motor_pwm_lane #(
  parameter int N_MOTOR_RATE = 36,
  parameter int FRAC_BITS    = 16,
  parameter int FC_W         = 12,
  parameter int SLEW_US      = 50
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [N_MOTOR_RATE-1:0] rate,
  input  logic                    armed,
  input  logic                    latch,
  input  logic [FC_W-1:0]         frame_cnt,
  output logic                    pwm
);
  logic signed [N_MOTOR_RATE-1:0] shifted;
  logic [9:0]      target_d, target_q;
  logic [FC_W-1:0] width_q, goal, next_w;

  // Integer part of the rate clamped to 0..1000 us of extra pulse width.
  always_comb begin
    shifted = $signed(rate) >>> FRAC_BITS;
    if (!armed || shifted[N_MOTOR_RATE-1])
      target_d = '0;
    else if (shifted > $signed(N_MOTOR_RATE'(1000)))
      target_d = 10'd1000;
    else
      target_d = shifted[9:0];
  end

  assign goal = FC_W'(1000) + FC_W'(target_q);

`ifdef MOTOR_SLEW_LIMIT_EN
  localparam int SW = FC_W + 1;
  logic armed_q;

  always_ff @(posedge sys_clk or posedge rst)
    if (rst) armed_q <= 1'b0;
    else     armed_q <= armed;

  // Disarm bypasses the limiter so motors stop without ramping down.
  always_comb begin
    next_w = goal;
    if (!armed_q)
      next_w = FC_W'(1000);
    else if (SW'(goal) > SW'(width_q) + SW'(SLEW_US))
      next_w = width_q + FC_W'(SLEW_US);
    else if (SW'(goal) + SW'(SLEW_US) < SW'(width_q))
      next_w = width_q - FC_W'(SLEW_US);
  end
`else
  assign next_w = goal;
`endif

  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      target_q <= '0;
      width_q  <= FC_W'(1000);
      pwm      <= 1'b0;
    end else begin
      target_q <= target_d;
      if (latch) width_q <= next_w;
      pwm <= (frame_cnt < width_q);
    end
endmodule

module motor_pwm_gen #(
  parameter int N_MOTOR_RATE = 36,
  parameter int FRAC_BITS    = 16,
  parameter int CLKS_PER_US  = 38,
  parameter int FRAME_US     = 2500,
  parameter int SLEW_US      = 50
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [N_MOTOR_RATE-1:0] motor_1_rate,
  input  logic [N_MOTOR_RATE-1:0] motor_2_rate,
  input  logic [N_MOTOR_RATE-1:0] motor_3_rate,
  input  logic [N_MOTOR_RATE-1:0] motor_4_rate,
  input  logic                    armed,
  output logic                    motor_1_pwm,
  output logic                    motor_2_pwm,
  output logic                    motor_3_pwm,
  output logic                    motor_4_pwm,
  output logic                    frame_start
);
  localparam int PC_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int FC_W = $clog2(FRAME_US);

  logic [PC_W-1:0] pre_cnt;
  logic [FC_W-1:0] frame_cnt;
  logic            us_tick, latch;
  logic [3:0][N_MOTOR_RATE-1:0] rate;
  logic [3:0]      pwm;

  assign rate    = {motor_4_rate, motor_3_rate, motor_2_rate, motor_1_rate};
  assign us_tick = (pre_cnt == PC_W'(CLKS_PER_US - 1));
  assign latch   = us_tick && (frame_cnt == FC_W'(FRAME_US - 1));

  // frame_start is registered alongside the pwm outputs so it coincides with their rising edge.
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      pre_cnt     <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      pre_cnt <= us_tick ? '0 : pre_cnt + 1'b1;
      if (us_tick) frame_cnt <= latch ? '0 : frame_cnt + 1'b1;
      frame_start <= (pre_cnt == '0) && (frame_cnt == '0);
    end

  for (genvar m = 0; m < 4; m++) begin : g_lane
    motor_pwm_lane #(
      .N_MOTOR_RATE(N_MOTOR_RATE),
      .FRAC_BITS   (FRAC_BITS),
      .FC_W        (FC_W),
      .SLEW_US     (SLEW_US)
    ) u_lane (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .rate     (rate[m]),
      .armed    (armed),
      .latch    (latch),
      .frame_cnt(frame_cnt),
      .pwm      (pwm[m])
    );
  end

  assign {motor_4_pwm, motor_3_pwm, motor_2_pwm, motor_1_pwm} = pwm;
endmodule

// File: tb/tb_motor_pwm_gen.sv
// Scoreboard bench for motor_pwm_gen: per-frame pulse widths measured and compared to a rate->width model.
module tb_motor_pwm_gen;
  localparam int NR = 36, FB = 16, CPU = 2, FUS = 2010, SLEW = 50;
  localparam int FRAME_CYC = CPU * FUS;

  logic          sys_clk = 1'b0, rst = 1'b1, armed = 1'b0;
  logic [NR-1:0] rate [4];
  logic          p1, p2, p3, p4, frame_start;
  logic [3:0]    pwm;

  assign pwm = {p4, p3, p2, p1};
  always #5 sys_clk = ~sys_clk;

  motor_pwm_gen #(.N_MOTOR_RATE(NR), .FRAC_BITS(FB), .CLKS_PER_US(CPU),
                  .FRAME_US(FUS), .SLEW_US(SLEW)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .motor_1_rate(rate[0]), .motor_2_rate(rate[1]),
    .motor_3_rate(rate[2]), .motor_4_rate(rate[3]),
    .armed(armed),
    .motor_1_pwm(p1), .motor_2_pwm(p2), .motor_3_pwm(p3), .motor_4_pwm(p4),
    .frame_start(frame_start)
  );

  typedef struct { int w [4]; } frame_t;
  frame_t sb [$];
  int n_chk = 0, n_fail = 0;
  int model_w [4];

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse width in us implied by a rate: 1000 + clamp(floor(rate / 2^FB), 0, 1000), 0 offset when disarmed.
  function automatic int target_w(logic [NR-1:0] r, bit arm);
    logic signed [NR-1:0] rs;
    longint s, ip;
    rs = r;
    s  = rs;
    ip = s >>> FB;
    if (!arm || ip < 0) return 1000;
    if (ip > 1000)      return 2000;
    return 1000 + int'(ip);
  endfunction

  task automatic push_expect();
    frame_t f;
    for (int m = 0; m < 4; m++) begin
      int g;
      g = target_w(rate[m], armed);
`ifdef MOTOR_SLEW_LIMIT_EN
      if (!armed)                      model_w[m] = 1000;
      else if (g > model_w[m] + SLEW)  model_w[m] = model_w[m] + SLEW;
      else if (g < model_w[m] - SLEW)  model_w[m] = model_w[m] - SLEW;
      else                             model_w[m] = g;
`else
      model_w[m] = g;
`endif
      f.w[m] = model_w[m];
    end
    sb.push_back(f);
  endtask

  task automatic push_idle();
    frame_t f;
    for (int m = 0; m < 4; m++) begin
      model_w[m] = 1000;
      f.w[m] = 1000;
    end
    sb.push_back(f);
  endtask

  function automatic logic [NR-1:0] rand_rate();
    longint ip;
    ip = longint'($urandom_range(3200)) - 1100;
    return NR'((ip <<< FB) + longint'($urandom_range(65535)));
  endfunction

  // Monitor: measures each frame between frame_start pulses and checks it against the scoreboard.
  int  hi_cnt [4];
  int  len;
  bit  measuring = 1'b0;
  always @(negedge sys_clk) begin
    if (rst) measuring = 1'b0;
    else begin
      if (frame_start) begin
        if (measuring) begin
          if (sb.size() == 0) check("sb_unexpected_frame", 1, 0);
          else begin
            frame_t e;
            e = sb.pop_front();
            check("frame_len", len, FRAME_CYC);
            for (int m = 0; m < 4; m++)
              check($sformatf("width_m%0d", m + 1), hi_cnt[m], e.w[m] * CPU);
          end
        end
        check("rise_aligned", int'(pwm), 15);
        measuring = 1'b1;
        len = 0;
        for (int m = 0; m < 4; m++) hi_cnt[m] = 0;
      end
      if (measuring) begin
        len++;
        for (int m = 0; m < 4; m++) hi_cnt[m] += int'(pwm[m]);
      end
    end
  end

  task automatic wait_fs();
    int t;
    t = 0;
    do begin
      @(negedge sys_clk);
      t++;
    end while (!frame_start && t < 2 * FRAME_CYC);
    if (!frame_start) check("frame_start_timeout", 0, 1);
  endtask

  task automatic mid_frame();
    repeat ($urandom_range(2000, 10)) @(negedge sys_clk);
  endtask

  initial begin
    int t;
    for (int m = 0; m < 4; m++) rate[m] = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_fs", int'(frame_start), 0);
    push_idle();
    @(negedge sys_clk) rst = 1'b0;
    @(posedge sys_clk) #1;
    check("release_fs", int'(frame_start), 1);
    check("release_pwm", int'(pwm), 15);

    // Mixed offsets, truncation of fraction, negative and over-range clamps.
    wait_fs(); mid_frame();
    rate[0] = NR'(500 << 16);
    rate[1] = NR'(-(longint'(5) <<< 16));
    rate[2] = NR'(2000 << 16);
    rate[3] = NR'((250 << 16) + 'hFFFF);
    armed = 1'b1;
    push_expect();

    wait_fs(); mid_frame();
    rate[0] = NR'(100 << 16);
    push_expect();

    // Mid-pulse change must not disturb the frame in progress.
    wait_fs(); repeat (50) @(negedge sys_clk);
    rate[0] = NR'(900 << 16);
    push_expect();

    wait_fs(); mid_frame();
    rate[0] = 36'h8_0000_0000;
    rate[1] = 36'h7_FFFF_FFFF;
    rate[2] = NR'(1001 << 16);
    rate[3] = NR'((1000 << 16) + 'hFFFF);
    push_expect();

    wait_fs(); mid_frame();
    rate[0] = NR'('hFFFF);
    rate[1] = NR'(1000 << 16);
    rate[2] = 36'hF_FFFF_FFFF;
    rate[3] = NR'(999 << 16);
    push_expect();

    for (int k = 0; k < 4; k++) begin
      wait_fs(); mid_frame();
      for (int m = 0; m < 4; m++) rate[m] = rand_rate();
      armed = ($urandom_range(3) != 0);
      push_expect();
    end

    wait_fs(); mid_frame();
    for (int m = 0; m < 4; m++) rate[m] = NR'(1500 << 16);
    armed = 1'b0;
    push_expect();

    // Reset during the high phase of a pulse.
    wait_fs(); repeat (100) @(negedge sys_clk);
    @(posedge sys_clk) #1 rst = 1'b1;
    #1;
    check("async_rst_pwm", int'(pwm), 0);
    check("async_rst_fs", int'(frame_start), 0);
    sb.delete();
    push_idle();
    armed = 1'b1;
    for (int m = 0; m < 4; m++) rate[m] = rand_rate();
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(posedge sys_clk) #1;
    check("rerelease_fs", int'(frame_start), 1);
    check("rerelease_pwm", int'(pwm), 15);

    wait_fs(); mid_frame();
    push_expect();
    wait_fs(); mid_frame();
    for (int m = 0; m < 4; m++) rate[m] = rand_rate();
    push_expect();

    t = 0;
    while (sb.size() > 0 && t < 3 * FRAME_CYC) begin
      @(negedge sys_clk);
      t++;
    end
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
